// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-slave / local-host RAM arbiter:
// command codes, arbiter state encoding and default widths.
package spi_ram_pkg;

  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_SIZE_DEF = 8;
  localparam int RX_W          = 10;
  localparam int TX_W          = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SPI_OP  = 2'b01,
    HOST_OP = 2'b10,
    RD_RESP = 2'b11
  } arb_state_e;

  // Memory commands occupy the pending buffer; address loads never do.
  function automatic logic is_mem_cmd(input spi_cmd_e cmd);
    return (cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA);
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Local host request bus of the RAM arbiter: the host is the master,
// the arbiter the slave.
interface ram_access_arbiter_if
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) ();

  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [DATA_SIZE-1:0] host_wdata;
  logic                 host_gnt;
  logic [DATA_SIZE-1:0] host_rdata;
  logic                 host_rvalid;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid
  );

endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI frame decoder: address registers, one-entry pending memory op and
// the sticky overflow flag for memory commands that found the buffer busy.
module spi_cmd_decoder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RX_W-1:0]      rx_data,
  input  logic                 rx_valid,
  input  logic                 spi_free,
  output logic                 pend_valid,
  output logic                 pend_we,
  output logic [ADDR_SIZE-1:0] pend_addr,
  output logic [DATA_SIZE-1:0] pend_wdata,
  output logic                 spi_ovf
);

  spi_cmd_e             cmd_s;
  logic [ADDR_SIZE-1:0] wr_addr_q,    wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q,    rd_addr_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 pend_we_q,    pend_we_d;
  logic [ADDR_SIZE-1:0] pend_addr_q,  pend_addr_d;
  logic [DATA_SIZE-1:0] pend_wdata_q, pend_wdata_d;
  logic                 ovf_q,        ovf_d;

  assign cmd_s = spi_cmd_e'(rx_data[9:8]);

  // A queued op captures the address register as it stands at acceptance;
  // a buffer being freed this cycle may be refilled in the same cycle.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    ovf_d        = ovf_q;
    if (spi_free) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    if (rx_valid) begin
      case (cmd_s)
        CMD_WR_ADDR: wr_addr_d = ADDR_SIZE'(rx_data[7:0]);
        CMD_RD_ADDR: rd_addr_d = ADDR_SIZE'(rx_data[7:0]);
        CMD_WR_DATA, CMD_RD_DATA: begin
          if (!pend_valid_q || spi_free) begin
            pend_valid_d = 1'b1;
            pend_we_d    = (cmd_s == CMD_WR_DATA);
            pend_addr_d  = (cmd_s == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
            pend_wdata_d = DATA_SIZE'(rx_data[7:0]);
          end else begin
            ovf_d = is_mem_cmd(cmd_s);
          end
        end
        default: ovf_d = ovf_q;
      endcase
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q    <= {ADDR_SIZE{1'b0}};
      rd_addr_q    <= {ADDR_SIZE{1'b0}};
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= {ADDR_SIZE{1'b0}};
      pend_wdata_q <= {DATA_SIZE{1'b0}};
      ovf_q        <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_we    = pend_we_q;
  assign pend_addr  = pend_addr_q;
  assign pend_wdata = pend_wdata_q;
  assign spi_ovf    = ovf_q;

endmodule

// File: rtl/ram_access_arbiter.sv
// Single-port RAM arbiter between an SPI-slave command stream and a local
// host; one access in flight, round-robin on ties, registered outputs.
module ram_access_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [RX_W-1:0]       rx_data,
  input  logic                  rx_valid,
  output logic [TX_W-1:0]       tx_data,
  output logic                  tx_valid,
  ram_access_arbiter_if.slave   host,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_SIZE-1:0]  ram_addr,
  output logic [DATA_SIZE-1:0]  ram_wdata,
  input  logic [DATA_SIZE-1:0]  ram_rdata,
  output logic                  spi_ovf
);

  arb_state_e           state_q;
  logic                 host_prio_q;
  logic                 src_host_q;
  logic                 rd_op_q;
  logic [TX_W-1:0]      tx_data_q;
  logic                 tx_valid_q;
  logic                 host_gnt_q;
  logic [DATA_SIZE-1:0] host_rdata_q;
  logic                 host_rvalid_q;
  logic                 ram_en_q;
  logic                 ram_we_q;
  logic [ADDR_SIZE-1:0] ram_addr_q;
  logic [DATA_SIZE-1:0] ram_wdata_q;

  logic                 spi_free_s;
  logic                 pend_valid_s;
  logic                 pend_we_s;
  logic [ADDR_SIZE-1:0] pend_addr_s;
  logic [DATA_SIZE-1:0] pend_wdata_s;

  assign spi_free_s = (state_q == SPI_OP);

  spi_cmd_decoder #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_dec (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .spi_free   (spi_free_s),
    .pend_valid (pend_valid_s),
    .pend_we    (pend_we_s),
    .pend_addr  (pend_addr_s),
    .pend_wdata (pend_wdata_s),
    .spi_ovf    (spi_ovf)
  );

  // Arbiter FSM; host_prio_q set means the host wins the next tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      host_prio_q   <= 1'b0;
      src_host_q    <= 1'b0;
      rd_op_q       <= 1'b0;
      tx_data_q     <= {TX_W{1'b0}};
      tx_valid_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rdata_q  <= {DATA_SIZE{1'b0}};
      host_rvalid_q <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= {ADDR_SIZE{1'b0}};
      ram_wdata_q   <= {DATA_SIZE{1'b0}};
    end else begin
      tx_valid_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_valid_s && !(host.host_req && host_prio_q)) begin
            state_q     <= SPI_OP;
            ram_en_q    <= 1'b1;
            ram_we_q    <= pend_we_s;
            ram_addr_q  <= pend_addr_s;
            ram_wdata_q <= pend_wdata_s;
            src_host_q  <= 1'b0;
            rd_op_q     <= !pend_we_s;
            host_prio_q <= 1'b1;
          end else if (host.host_req) begin
            state_q     <= HOST_OP;
            ram_en_q    <= 1'b1;
            ram_we_q    <= host.host_we;
            ram_addr_q  <= host.host_addr;
            ram_wdata_q <= host.host_wdata;
            host_gnt_q  <= 1'b1;
            src_host_q  <= 1'b1;
            rd_op_q     <= !host.host_we;
            host_prio_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        SPI_OP, HOST_OP: begin
          state_q <= rd_op_q ? RD_RESP : IDLE;
        end
        RD_RESP: begin
          if (src_host_q) begin
            host_rdata_q  <= ram_rdata;
            host_rvalid_q <= 1'b1;
          end else begin
            tx_data_q  <= TX_W'(ram_rdata);
            tx_valid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign host.host_gnt    = host_gnt_q;
  assign host.host_rdata  = host_rdata_q;
  assign host.host_rvalid = host_rvalid_q;
  assign ram_en           = ram_en_q;
  assign ram_we           = ram_we_q;
  assign ram_addr         = ram_addr_q;
  assign ram_wdata        = ram_wdata_q;

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8, RAM address width.
REQ-002 Parameter DATA_SIZE, default 8, RAM data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_data  input  10  SPI-slave frame: [9:8] command, [7:0] address or data.
REQ-006 rx_valid  input  1  one-cycle pulse; rx_data valid.
REQ-007 tx_data  output  8  SPI read-response data to slave.
REQ-008 tx_valid  output  1  one-cycle pulse; tx_data updated.
REQ-009 host_req, host_we  input  1 each  local host request and write-enable; held until grant.
REQ-010 host_addr, host_wdata  input  ADDR_SIZE, DATA_SIZE  host address and write data; held until grant.
REQ-011 host_gnt  output  1  one-cycle pulse; host access issued.
REQ-012 host_rdata, host_rvalid  output  DATA_SIZE, 1  host read data and one-cycle valid pulse.
REQ-013 ram_en, ram_we  output  1 each  RAM port strobe and write-enable.
REQ-014 ram_addr, ram_wdata  output  ADDR_SIZE, DATA_SIZE  RAM address and write data.
REQ-015 ram_rdata  input  DATA_SIZE  RAM read data, valid one cycle after a read strobe.
REQ-016 spi_ovf  output  1  sticky flag; an SPI memory command was dropped.

Function
REQ-017 Commands on rx_valid: 00 load wr_addr, 01 write data to wr_addr, 10 load rd_addr, 11 read from rd_addr.
REQ-018 Commands 00 and 10 update the address register on the rx_valid edge, use no RAM cycle, and never set a pending request.
REQ-019 Commands 01 and 11 load a one-entry SPI pending buffer with op, data and the address current at acceptance; later address loads do not alter a queued op.
REQ-020 A command 01 or 11 arriving while the buffer is full and not freed that cycle is dropped and sets spi_ovf.
REQ-021 A command arriving in the cycle the buffer is granted is accepted.
REQ-022 FSM states: IDLE, SPI_OP, HOST_OP, RD_RESP.
REQ-023 IDLE -> SPI_OP when only SPI is pending; IDLE -> HOST_OP when only host_req is high; otherwise IDLE.
REQ-024 When both are pending, grant the requester not served last; after reset, SPI wins the first tie.
REQ-025 SPI_OP and HOST_OP last exactly one cycle: ram_en=1, ram_we and ram_addr/ram_wdata taken from the granted source.
REQ-026 host_gnt=1 only during HOST_OP; the SPI pending buffer clears on leaving SPI_OP.
REQ-027 After a write op the FSM goes to IDLE; after a read op it goes to RD_RESP.
REQ-028 RD_RESP: ram_en=0; ram_rdata is registered into tx_data (SPI read) or host_rdata (host read), and the matching valid pulses high in the next cycle only; then IDLE.
REQ-029 ram_en=0 and ram_we=0 in IDLE and RD_RESP.
REQ-030 tx_data and host_rdata hold their values until the next read response of the same source.
REQ-031 Uncontended SPI read latency: rx_valid at edge T gives tx_valid high in cycle T+4. Worst case adds one host op (2 cycles).
REQ-032 Only one access is in flight: no new grant while in SPI_OP, HOST_OP or RD_RESP.

Reset
REQ-033 On rst_n=0: FSM to IDLE; pending buffer, wr_addr, rd_addr and last-served cleared (SPI favoured).
REQ-034 On rst_n=0: tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr, ram_wdata and spi_ovf all set to 0.
REQ-035 Reset mid-access aborts the access and produces no valid pulse.

Structure
REQ-036 Shared package spi_ram_pkg holds the command codes (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11), the FSM state encoding and default widths.
REQ-037 One sub-module, spi_cmd_decoder, implements command decode, the address registers, the pending buffer and spi_ovf; the arbiter FSM lives in the top.

Verification
REQ-038 SPI 00 0x12, then 01 0xAB -> one cycle with ram_en=1, ram_we=1, ram_addr=0x12, ram_wdata=0xAB.
REQ-039 SPI 10 0x12, then 11 xx with ram_rdata=0xAB -> tx_data=0xAB and a one-cycle tx_valid, 4 cycles after rx_valid.
REQ-040 SPI read pending with host_req (read 0x05) raised in the same cycle, first tie after reset -> SPI served first, then host_gnt; host_rdata=RAM[0x05] with host_rvalid.
REQ-041 Back-to-back ties -> grants alternate SPI, host, SPI; no starvation over 10 ties.
REQ-042 Two 01 commands with the first blocked by a continuous host_req -> second dropped, spi_ovf=1 held until reset.
REQ-043 rst_n low during RD_RESP -> no tx_valid; all outputs 0 on the next cycle.
